// File: rtl/multicycle_ctrl_pkg.sv
// ctrl_pkg: state encoding, opcodes and datapath select codes for the
// multi-cycle sequencer. Optional feature macro: CTRL_ILLEGAL_TRAP_EN.
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_e;

    localparam logic [3:0] OP_RTYPE = 4'h0;
    localparam logic [3:0] OP_ADDI  = 4'h1;
    localparam logic [3:0] OP_LW    = 4'h2;
    localparam logic [3:0] OP_SW    = 4'h3;
    localparam logic [3:0] OP_BEQ   = 4'h4;
    localparam logic [3:0] OP_JMP   = 4'h5;
    localparam logic [3:0] OP_HALT  = 4'hF;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_REGB = 2'b00;
    localparam logic [1:0] SRCB_ONE  = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    typedef struct packed {
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       mem_to_reg;
        logic       reg_write;
        logic       halted;
        logic       illegal;
    } ctrl_t;

    function automatic logic is_legal(input logic [3:0] op);
        return (op <= OP_JMP) || (op == OP_HALT);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath/memory/register-file bundle.
// master = sequencer side, slave = datapath side.
interface multicycle_ctrl_if;
    logic [15:0] instr;
    logic        mem_ready;
    logic        zero;
    logic        IRWrite;
    logic        PCWrite;
    logic [1:0]  PCSrc;
    logic        MemRead;
    logic        MemWrite;
    logic        IorD;
    logic        ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [2:0]  ALUOp;
    logic        MemtoReg;
    logic [2:0]  Read1;
    logic [2:0]  Read2;
    logic [2:0]  WriteReg;
    logic        RegWrite;
    logic        halted;
    logic        illegal;

    modport master (
        input  instr, mem_ready, zero,
        output IRWrite, PCWrite, PCSrc, MemRead, MemWrite, IorD, ALUSrcA,
               ALUSrcB, ALUOp, MemtoReg, Read1, Read2, WriteReg, RegWrite,
               halted, illegal
    );

    modport slave (
        output instr, mem_ready, zero,
        input  IRWrite, PCWrite, PCSrc, MemRead, MemWrite, IorD, ALUSrcA,
               ALUSrcB, ALUOp, MemtoReg, Read1, Read2, WriteReg, RegWrite,
               halted, illegal
    );
endinterface

// File: rtl/multicycle_ctrl_decode.sv
// ctrl_decode: combinational control-word decode from state and IR fields.
// CTRL_ILLEGAL_TRAP_EN enables the sticky illegal flag in HALT.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  state_e     state_i,
    input  logic [3:0] op_i,
    input  logic [2:0] funct_i,
    input  logic       zero_i,
    input  logic       mem_ready_i,
    output ctrl_t      ctrl_o
);

    // Moore decode per state; only IRWrite/PCWrite look at mem_ready/zero
    always_comb begin
        ctrl_o = '0;
        unique case (state_i)
            S_FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.alu_src_b = SRCB_ONE;
                ctrl_o.ir_write  = mem_ready_i;
                ctrl_o.pc_write  = mem_ready_i;
            end
            S_DECODE: ctrl_o.alu_src_b = SRCB_IMM;
            S_EXEC: begin
                case (op_i)
                    OP_RTYPE: begin
                        ctrl_o.alu_src_a = 1'b1;
                        ctrl_o.alu_op    = funct_i;
                    end
                    OP_ADDI, OP_LW, OP_SW: begin
                        ctrl_o.alu_src_a = 1'b1;
                        ctrl_o.alu_src_b = SRCB_IMM;
                    end
                    OP_BEQ: begin
                        ctrl_o.alu_src_a = 1'b1;
                        ctrl_o.alu_op    = ALU_SUB;
                        ctrl_o.pc_src    = PCSRC_ALUOUT;
                        ctrl_o.pc_write  = zero_i;
                    end
                    OP_JMP: begin
                        ctrl_o.pc_src   = PCSRC_JUMP;
                        ctrl_o.pc_write = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                ctrl_o.iord      = 1'b1;
                ctrl_o.mem_read  = (op_i == OP_LW);
                ctrl_o.mem_write = (op_i == OP_SW);
            end
            S_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = (op_i == OP_LW);
            end
            S_HALT: begin
                ctrl_o.halted = 1'b1;
`ifdef CTRL_ILLEGAL_TRAP_EN
                // IR is frozen in HALT, so the trapping opcode is still there
                ctrl_o.illegal = !is_legal(op_i);
`endif
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB sequencer holding state and IR.
// Optional macro CTRL_ILLEGAL_TRAP_EN: illegal opcodes halt instead of NOP.
module multicycle_ctrl
    import ctrl_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    multicycle_ctrl_if.master bus
);

    state_e      state_q, state_d;
    logic [15:0] ir_q, ir_d;
    ctrl_t       c;

    wire [3:0] op    = ir_q[15:12];
    wire [2:0] rd    = ir_q[11:9];
    wire [2:0] rs    = ir_q[8:6];
    wire [2:0] rt    = ir_q[5:3];
    wire [2:0] funct = ir_q[2:0];

    ctrl_decode u_dec (
        .state_i    (state_q),
        .op_i       (op),
        .funct_i    (funct),
        .zero_i     (bus.zero),
        .mem_ready_i(bus.mem_ready),
        .ctrl_o     (c)
    );

    // Next state and IR load
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        if (c.ir_write) ir_d = bus.instr;
        unique case (state_q)
            S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                if (op == OP_HALT)  state_d = S_HALT;
                else if (is_legal(op)) state_d = S_EXEC;
`ifdef CTRL_ILLEGAL_TRAP_EN
                else state_d = S_HALT;
`else
                else state_d = S_FETCH;
`endif
            end
            S_EXEC: begin
                case (op)
                    OP_RTYPE, OP_ADDI: state_d = S_WB;
                    OP_LW, OP_SW:      state_d = S_MEM;
                    default:           state_d = S_FETCH;
                endcase
            end
            S_MEM:  if (bus.mem_ready) state_d = (op == OP_LW) ? S_WB : S_FETCH;
            S_WB:   state_d = S_FETCH;
            S_HALT: state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    // State and IR registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_FETCH;
            ir_q    <= 16'h0000;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    // Every enable is forced low while reset is held, so an interrupted
    // access never completes.
    assign bus.IRWrite  = c.ir_write  & ~rst_i;
    assign bus.PCWrite  = c.pc_write  & ~rst_i;
    assign bus.MemRead  = c.mem_read  & ~rst_i;
    assign bus.MemWrite = c.mem_write & ~rst_i;
    assign bus.RegWrite = c.reg_write & ~rst_i;
    assign bus.halted   = c.halted    & ~rst_i;
    assign bus.illegal  = c.illegal   & ~rst_i;
    assign bus.IorD     = c.iord      & ~rst_i;
    assign bus.PCSrc    = c.pc_src;
    assign bus.ALUSrcA  = c.alu_src_a;
    assign bus.ALUSrcB  = c.alu_src_b;
    assign bus.ALUOp    = c.alu_op;
    assign bus.MemtoReg = c.mem_to_reg & ~rst_i;

    assign bus.Read1    = rs;
    assign bus.Read2    = (op == OP_SW || op == OP_BEQ) ? rd : rt;
    assign bus.WriteReg = rd;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: phase-level reference model compared every
// negedge, plus directed instruction runs with literal expectations.
module tb_multicycle_ctrl;

    typedef struct packed {
        logic       irw, pcw;
        logic [1:0] pcs;
        logic       mrd, mwr, iord, srca;
        logic [1:0] srcb;
        logic [2:0] aop;
        logic       m2r;
        logic [2:0] r1, r2, wr;
        logic       rw, hlt, ill;
    } ov_t;

    localparam int P_FETCH = 0, P_DEC = 1, P_EXEC = 2, P_MEM = 3, P_WB = 4, P_HALT = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multicycle_ctrl_if bus();
    multicycle_ctrl dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    int checks = 0, passed = 0;
    ov_t act;
    ov_t tr [0:63];
    int  ncyc;

    assign act = '{irw:bus.IRWrite, pcw:bus.PCWrite, pcs:bus.PCSrc, mrd:bus.MemRead,
                   mwr:bus.MemWrite, iord:bus.IorD, srca:bus.ALUSrcA, srcb:bus.ALUSrcB,
                   aop:bus.ALUOp, m2r:bus.MemtoReg, r1:bus.Read1, r2:bus.Read2,
                   wr:bus.WriteReg, rw:bus.RegWrite, hlt:bus.halted, ill:bus.illegal};

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a === e) passed++;
        else $display("FAIL %s: got %h, required %h (t=%0t)", n, a, e, $time);
    endtask

    // ---------------- reference model ----------------
    int          m_ph = P_FETCH;
    logic [15:0] m_ir = 16'h0;
    bit          m_valid = 0;

    function automatic bit legal(input logic [3:0] op);
        return (op <= 4'd5) || (op == 4'hF);
    endfunction

    // Expected outputs straight from the per-phase control table
    function automatic ov_t mexp(input int ph, input logic [15:0] ir, input bit mr,
                                 input bit z, input bit r);
        ov_t e;
        logic [3:0] op;
        op = ir[15:12];
        e = '0;
        e.r1 = ir[8:6];
        e.r2 = (op == 4'd3 || op == 4'd4) ? ir[11:9] : ir[5:3];
        e.wr = ir[11:9];
        case (ph)
            P_FETCH: begin e.mrd = 1; e.srcb = 2'b01; e.irw = mr; e.pcw = mr; end
            P_DEC:   e.srcb = 2'b10;
            P_EXEC: begin
                if (op == 4'd0) begin e.srca = 1; e.aop = ir[2:0]; end
                else if (op >= 4'd1 && op <= 4'd3) begin e.srca = 1; e.srcb = 2'b10; end
                else if (op == 4'd4) begin e.srca = 1; e.aop = 3'b001; e.pcs = 2'b01; e.pcw = z; end
                else if (op == 4'd5) begin e.pcs = 2'b10; e.pcw = 1; end
            end
            P_MEM: begin e.iord = 1; e.mrd = (op == 4'd2); e.mwr = (op == 4'd3); end
            P_WB:  begin e.rw = 1; e.m2r = (op == 4'd2); end
            P_HALT: begin
                e.hlt = 1;
`ifdef CTRL_ILLEGAL_TRAP_EN
                e.ill = !legal(op);
`endif
            end
            default: ;
        endcase
        if (r) begin
            e.irw = 0; e.pcw = 0; e.mrd = 0; e.mwr = 0; e.iord = 0;
            e.rw = 0; e.hlt = 0; e.ill = 0; e.m2r = 0;
        end
        return e;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_ph = P_FETCH; m_ir = 16'h0; m_valid = 1;
        end else begin
            case (m_ph)
                P_FETCH: if (bus.mem_ready) begin m_ir = bus.instr; m_ph = P_DEC; end
                P_DEC: begin
                    if (m_ir[15:12] == 4'hF) m_ph = P_HALT;
                    else if (legal(m_ir[15:12])) m_ph = P_EXEC;
`ifdef CTRL_ILLEGAL_TRAP_EN
                    else m_ph = P_HALT;
`else
                    else m_ph = P_FETCH;
`endif
                end
                P_EXEC: m_ph = (m_ir[15:12] <= 4'd1) ? P_WB :
                               (m_ir[15:12] <= 4'd3) ? P_MEM : P_FETCH;
                P_MEM: if (bus.mem_ready) m_ph = (m_ir[15:12] == 4'd2) ? P_WB : P_FETCH;
                P_WB:  m_ph = P_FETCH;
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        if (m_valid) chk("model", act, mexp(m_ph, m_ir, bus.mem_ready, bus.zero, rst));
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Runs one instruction from FETCH until the next FETCH (or HALT),
    // holding mem_ready low for 'waits' cycles of the MEM phase.
    task automatic run(input logic [15:0] w, input int waits, input bit z);
        int waited;
        waited = 0; ncyc = 0;
        bus.instr = w; bus.zero = z;
        do begin
            bus.mem_ready = !(bus.IorD && waited < waits);
            if (bus.IorD && !bus.mem_ready) waited++;
            #1;
            tr[ncyc] = act;
            tick();
            ncyc++;
        end while (!(bus.MemRead && !bus.IorD) && !bus.halted && ncyc < 40);
        chk("run_timeout", 32'(ncyc < 40), 32'd1);
    endtask

    task automatic do_reset();
        rst = 1; bus.mem_ready = 0;
        tick(); tick();
        chk("rst_enables", {bus.IRWrite, bus.PCWrite, bus.MemRead, bus.MemWrite,
                            bus.RegWrite, bus.halted, bus.illegal}, 0);
        rst = 0; #1;
    endtask

    initial begin
        bus.instr = 16'h0; bus.mem_ready = 0; bus.zero = 0;
        do_reset();
        chk("after_rst_fetch", {bus.MemRead, bus.IorD, bus.ALUSrcB, bus.Read1, bus.Read2}, {1'b1, 1'b0, 2'b01, 6'd0});

        // R-type XOR
        run(16'h0A14, 0, 0);
        chk("r_cycles", ncyc, 4);
        chk("r_exec_aluop", tr[2].aop, 3'b100);
        chk("r_exec_src", {tr[2].srca, tr[2].srcb}, 3'b100);
        chk("r_wb", {tr[3].rw, tr[3].wr, tr[3].r1, tr[3].r2}, {1'b1, 3'd5, 3'd0, 3'd2});

        // LW with 3 wait cycles
        run(16'h2443, 3, 0);
        chk("lw_cycles", ncyc, 8);
        for (int i = 3; i <= 6; i++) chk("lw_mem_hold", {tr[i].mrd, tr[i].iord}, 2'b11);
        chk("lw_wb", {tr[7].rw, tr[7].m2r, tr[7].wr}, {1'b1, 1'b1, 3'd2});

        // BEQ taken / not taken
        run(16'h4281, 0, 1);
        chk("beq_t_cycles", ncyc, 3);
        chk("beq_t_exec", {tr[2].pcw, tr[2].pcs, tr[2].aop}, {1'b1, 2'b01, 3'b001});
        run(16'h4281, 0, 0);
        chk("beq_nt_cycles", ncyc, 3);
        chk("beq_nt_pcw", tr[2].pcw, 0);

        // ADDI, JMP, SW with ready memory
        run(16'h1A45, 0, 0);
        chk("addi_cycles", ncyc, 4);
        run(16'h5123, 0, 0);
        chk("jmp_cycles", ncyc, 3);
        chk("jmp_exec", {tr[2].pcw, tr[2].pcs}, 3'b110);
        run(16'h3642, 1, 0);
        chk("sw_cycles", ncyc, 5);
        chk("sw_mem", {tr[3].mwr, tr[4].mwr, tr[4].mrd, tr[4].r2}, {1'b1, 1'b1, 1'b0, 3'd3});

        // SW interrupted by reset in MEM
        bus.instr = 16'h3642; bus.mem_ready = 1;
        tick(); tick(); bus.mem_ready = 0; tick();
        chk("sw_in_mem", {bus.MemWrite, bus.IorD}, 2'b11);
        rst = 1; #1;
        chk("sw_rst_mwr", bus.MemWrite, 0);
        tick(); rst = 0; #1;
        chk("sw_rst_fetch", {bus.MemRead, bus.IorD, bus.Read1, bus.Read2, bus.WriteReg}, {2'b10, 9'd0});

        // Illegal opcode
        run(16'h7000, 0, 0);
        chk("ill_cycles", ncyc, 2);
`ifdef CTRL_ILLEGAL_TRAP_EN
        chk("ill_trap", {bus.halted, bus.illegal}, 2'b11);
        bus.mem_ready = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("ill_hold", {bus.IRWrite, bus.halted, bus.illegal}, 3'b011);
        end
        do_reset();
`else
        chk("ill_nop", {bus.MemRead, bus.IorD, bus.illegal, tr[0].ill, tr[1].ill}, 5'b10000);
`endif

        // HALT
        run(16'hF000, 0, 0);
        chk("halt_cycles", ncyc, 2);
        bus.mem_ready = 1;
        for (int i = 0; i < 20; i++) begin
            chk("halt_hold", {bus.halted, bus.illegal, bus.IRWrite, bus.PCWrite, bus.MemRead,
                              bus.MemWrite, bus.RegWrite}, 7'b1000000);
            tick();
        end
        do_reset();
        chk("halt_exit", {bus.halted, bus.MemRead}, 2'b01);

        tick();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got running, required finished");
        $fatal(1);
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Main sequencer of the 16-bit multi-cycle processor. Holds the instruction register and walks each instruction through FETCH/DECODE/EXEC/MEM/WB. Drives the datapath muxes, the memory strobes, the PC enable, and the register file port controls Read1/Read2/WriteReg/RegWrite. Memory accesses stall on a ready handshake.

## Interface
- No parameters; widths are fixed by the ISA: 16-bit instruction, 3-bit register index.
- clock  in  1  rising-edge clock, shared with the register file
- reset  in  1  synchronous, active-high
- instr  in  16  memory read data, sampled into IR
- mem_ready  in  1  memory completes the current access this cycle
- zero  in  1  ALU zero flag, valid in EXEC
- IRWrite, PCWrite  out  1  IR / PC load enables
- PCSrc  out  2  00 ALU result, 01 ALUOut, 10 jump target {PC[15:12],IR[11:0]}
- MemRead, MemWrite, IorD  out  1  memory strobes; IorD=1 selects ALUOut as address
- ALUSrcA  out  1  0 PC, 1 register A
- ALUSrcB  out  2  00 register B, 01 constant 1, 10 sext(IR[5:0])
- ALUOp  out  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT, 110 SLL, 111 SRL
- MemtoReg  out  1  write-back source is memory data
- Read1, Read2, WriteReg  out  3  register file addresses
- RegWrite  out  1  register file write enable
- halted  out  1  HALT state reached
- illegal  out  1  illegal opcode trapped (see Configuration)

## Operation
- IR fields:
  - op = IR[15:12], rd = IR[11:9], rs = IR[8:6], rt = IR[5:3], funct = IR[2:0], imm6 = IR[5:0].
- Opcodes:
  - 0000 R-type: ALUOp = funct.
  - 0001 ADDI, 0010 LW, 0011 SW, 0100 BEQ, 0101 JMP.
  - 1111 HALT.
  - All others are illegal.
- Read1 = rs. Read2 = rd for SW/BEQ, otherwise rt. WriteReg = rd.
- FETCH:
  - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ADD, PCSrc=00.
  - IRWrite and PCWrite assert only in the cycle mem_ready=1; that cycle moves to DECODE. Otherwise stay in FETCH.
- DECODE:
  - ALUSrcA=0, ALUSrcB=10, ADD; this latches the branch target into ALUOut.
  - HALT goes to HALT. Illegal goes to FETCH (NOP). All others go to EXEC.
- EXEC:
  - R-type: ALUSrcA=1, ALUSrcB=00, then WB.
  - ADDI/LW/SW: ALUSrcA=1, ALUSrcB=10, ADD. ADDI goes to WB; LW/SW go to MEM.
  - BEQ: ALUSrcA=1, ALUSrcB=00, SUB, PCSrc=01, PCWrite=zero, then FETCH.
  - JMP: PCSrc=10, PCWrite=1, then FETCH.
- MEM:
  - IorD=1. LW holds MemRead=1; SW holds MemWrite=1. Hold until mem_ready=1.
  - On mem_ready: LW goes to WB, SW goes to FETCH.
- WB: RegWrite=1 for exactly one cycle; MemtoReg=1 for LW only; then FETCH.
- HALT: all enables 0, halted=1. Only reset exits.

## Timing
- All outputs are Moore-decoded from state and IR, except IRWrite, PCWrite, and the MEM exit, which also depend on mem_ready or zero.
- Cycles per instruction with mem_ready tied high: R/ADDI 4, LW 5, SW 4, BEQ 3, JMP 3. Each memory wait cycle adds 1.
- Reset:
  - The next state is FETCH and IR becomes 0x0000.
  - In the cycle reset is high, every enable/strobe output is gated to 0 and halted=0, illegal=0.
  - Reset mid-MEM drops MemWrite in that same cycle; the partial access is discarded.
- IR changes only on IRWrite. Read1/Read2/WriteReg stay stable from DECODE through WB.
- A write to the register named in the next instruction is visible one cycle later; no forwarding is needed.

## Configuration
- CTRL_ILLEGAL_TRAP_EN defined:
  - An illegal opcode in DECODE goes to HALT with illegal=1, halted=1.
  - Both stay set until reset.
- Undefined:
  - An illegal opcode executes as a 2-cycle NOP (FETCH, DECODE, FETCH).
  - illegal is tied 0.

## Structure
- ctrl_pkg holds:
  - the state enum (FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5);
  - opcode constants;
  - ALUOp, PCSrc, and ALUSrcB codes.
- Sub-module ctrl_decode: combinational, takes (state, op, funct, zero, mem_ready) and returns the control outputs. The top level holds the state register and IR.

## Test plan
- Reset, then instr=0x0A14 (R-type, funct=100 XOR) with mem_ready=1:
  - Required sequence FETCH, DECODE, EXEC, WB.
  - EXEC shows ALUOp=100.
  - WB shows RegWrite=1, WriteReg=5, Read1=0, Read2=2.
- LW 0x2443 with mem_ready held low 3 cycles in MEM:
  - MemRead=1 and IorD=1 are held for 4 cycles.
  - Then WB with MemtoReg=1, WriteReg=2.
  - Total 8 cycles.
- BEQ 0x4281 with zero=1: EXEC shows PCWrite=1, PCSrc=01. With zero=0: PCWrite=0. Both go to FETCH after 3 cycles.
- SW 0x3642, then reset asserted in its MEM cycle:
  - MemWrite=0 in the reset cycle.
  - The next state is FETCH with IR=0x0000.
- Opcode 0x7000:
  - Without the macro: back in FETCH after 2 cycles, illegal=0.
  - With CTRL_ILLEGAL_TRAP_EN: HALT with illegal=1, no further IRWrite.
- HALT 0xF000: halted=1 from the cycle after DECODE; all enables stay 0 for 20 cycles until reset.
